// File: rtl/pipe_ctrl.sv
// Pipeline valid/payload sequencer: freeze, hold with bubble, front-end squash; PIPE_CTRL_STATS_EN adds stall/bubble counters.
// An entry reaches stage s s edges after acceptance; in_ready drops on stall_mem, hold or halt.
module pipe_ctrl #(
    parameter int DATA_W      = 16,
    parameter int STAGES      = 5,
    parameter int HOLD_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [DATA_W-1:0]          in_data,
    input  logic                       in_wwd,
    input  logic                       in_halt,
    input  logic                       stall_mem,
    input  logic                       hold,
    input  logic                       flush,
    output logic                       in_ready,
    output logic [STAGES-1:0]          stage_valid,
    output logic [STAGES*DATA_W-1:0]   stage_data,
    output logic [CNT_W-1:0]           num_inst,
    output logic [DATA_W-1:0]          output_port,
    output logic                       is_halted,
    output logic [CNT_W-1:0]           stall_cycles,
    output logic [CNT_W-1:0]           bubble_count
);

    localparam int PW = STAGES * DATA_W;

    // Hold keeps the stages under LO masks, shifts those under HI masks; the gap is the bubble stage.
    localparam logic [STAGES-1:0] LO_M  = {STAGES{1'b1}} >> (STAGES - HOLD_STAGES);
    localparam logic [STAGES-1:0] HI_M  = {STAGES{1'b1}} << (HOLD_STAGES + 1);
    localparam logic [PW-1:0]     LO_DM = {PW{1'b1}} >> ((STAGES - HOLD_STAGES) * DATA_W);
    localparam logic [PW-1:0]     HI_DM = {PW{1'b1}} << ((HOLD_STAGES + 1) * DATA_W);

    logic [STAGES-1:0] vld_q, vld_d;
    logic [STAGES-1:0] wwd_q, wwd_d;
    logic [STAGES-1:0] hlt_q, hlt_d;
    logic [PW-1:0]     dat_q, dat_d;
    logic [CNT_W-1:0]  num_q, num_d;
    logic [DATA_W-1:0] port_q, port_d;
    logic              halted_q, halted_d;

    logic              advance;
    logic              inject;
    logic              retire;
    logic              load_vld;
    logic [DATA_W-1:0] ld_dat;
    logic [DATA_W-1:0] ret_dat;

    assign advance  = !stall_mem && !hold;
    assign inject   = !stall_mem && hold;
    assign retire   = vld_q[STAGES-1] && !stall_mem && !halted_q;
    assign load_vld = in_valid && !flush && !halted_q;
    assign ld_dat   = load_vld ? in_data : '0;
    assign ret_dat  = dat_q[(STAGES-1)*DATA_W +: DATA_W];

    always_comb begin
        vld_d = vld_q;
        wwd_d = wwd_q;
        hlt_d = hlt_q;
        dat_d = dat_q;
        if (advance) begin
            vld_d = {vld_q[STAGES-2:0], load_vld};
            wwd_d = {wwd_q[STAGES-2:0], load_vld & in_wwd};
            hlt_d = {hlt_q[STAGES-2:0], load_vld & in_halt};
            dat_d = {dat_q[PW-DATA_W-1:0], ld_dat};
        end else if (inject) begin
            vld_d = (vld_q & LO_M) | ({vld_q[STAGES-2:0], 1'b0} & HI_M);
            wwd_d = (wwd_q & LO_M) | ({wwd_q[STAGES-2:0], 1'b0} & HI_M);
            hlt_d = (hlt_q & LO_M) | ({hlt_q[STAGES-2:0], 1'b0} & HI_M);
            dat_d = (dat_q & LO_DM) | ({dat_q[PW-DATA_W-1:0], {DATA_W{1'b0}}} & HI_DM);
        end
    end

    always_comb begin
        num_d    = num_q;
        port_d   = port_q;
        halted_d = halted_q;
        if (retire) begin
            num_d = num_q + CNT_W'(1);
            if (wwd_q[STAGES-1]) begin
                port_d = ret_dat;
            end
            if (hlt_q[STAGES-1]) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_q    <= '0;
            wwd_q    <= '0;
            hlt_q    <= '0;
            dat_q    <= '0;
            num_q    <= '0;
            port_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            wwd_q    <= wwd_d;
            hlt_q    <= hlt_d;
            dat_q    <= dat_d;
            num_q    <= num_d;
            port_q   <= port_d;
            halted_q <= halted_d;
        end
    end

`ifdef PIPE_CTRL_STATS_EN
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] bubble_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else if (!halted_q) begin
            if (stall_mem) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (inject) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
        end
    end

    assign stall_cycles = stall_q;
    assign bubble_count = bubble_q;
`else
    assign stall_cycles = '0;
    assign bubble_count = '0;
`endif

    assign in_ready    = !stall_mem && !hold && !halted_q;
    assign stage_valid = vld_q;
    assign stage_data  = dat_q;
    assign num_inst    = num_q;
    assign output_port = port_q;
    assign is_halted   = halted_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: hand-derived vector table, directed corner sequences, randomized run against a queue model.
module tb_pipe_ctrl;

    localparam int DATA_W      = 16;
    localparam int STAGES      = 5;
    localparam int HOLD_STAGES = 2;
    localparam int CNT_W       = 16;

`ifdef PIPE_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                     clk = 1'b0;
    logic                     reset_n;
    logic                     in_valid;
    logic [DATA_W-1:0]        in_data;
    logic                     in_wwd;
    logic                     in_halt;
    logic                     stall_mem;
    logic                     hold;
    logic                     flush;
    logic                     in_ready;
    logic [STAGES-1:0]        stage_valid;
    logic [STAGES*DATA_W-1:0] stage_data;
    logic [CNT_W-1:0]         num_inst;
    logic [DATA_W-1:0]        output_port;
    logic                     is_halted;
    logic [CNT_W-1:0]         stall_cycles;
    logic [CNT_W-1:0]         bubble_count;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .DATA_W(DATA_W), .STAGES(STAGES), .HOLD_STAGES(HOLD_STAGES), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_wwd(in_wwd), .in_halt(in_halt), .stall_mem(stall_mem), .hold(hold),
        .flush(flush), .in_ready(in_ready), .stage_valid(stage_valid),
        .stage_data(stage_data), .num_inst(num_inst), .output_port(output_port),
        .is_halted(is_halted), .stall_cycles(stall_cycles), .bubble_count(bubble_count)
    );

    typedef struct {
        logic              v;
        logic [DATA_W-1:0] d;
        logic              w;
        logic              h;
    } entry_t;

    // Reference: the pipe is a queue, index 0 = fetch latch, last element = retire stage.
    entry_t            m_pipe[$];
    logic [CNT_W-1:0]  m_num, m_sc, m_bc;
    logic [DATA_W-1:0] m_port;
    logic              m_halted;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        entry_t bub;
        bub = '{1'b0, '0, 1'b0, 1'b0};
        m_pipe.delete();
        for (int i = 0; i < STAGES; i++) m_pipe.push_back(bub);
        m_num = '0; m_sc = '0; m_bc = '0; m_port = '0; m_halted = 1'b0;
    endtask

    task automatic model_step();
        entry_t ret, inc, bub;
        bub = '{1'b0, '0, 1'b0, 1'b0};
        if (!reset_n) begin
            model_reset();
            return;
        end
        ret = m_pipe[STAGES-1];
        if (stall_mem) begin
            if (!m_halted) m_sc++;
            return;
        end
        if (hold) begin
            if (!m_halted) m_bc++;
            void'(m_pipe.pop_back());
            m_pipe.insert(HOLD_STAGES, bub);
        end else begin
            inc.v = in_valid && !flush && !m_halted;
            inc.d = inc.v ? in_data : '0;
            inc.w = inc.v && in_wwd;
            inc.h = inc.v && in_halt;
            void'(m_pipe.pop_back());
            m_pipe.push_front(inc);
        end
        if (ret.v && !m_halted) begin
            m_num++;
            if (ret.w) m_port = ret.d;
            if (ret.h) m_halted = 1'b1;
        end
    endtask

    task automatic compare_model();
        logic [STAGES-1:0]        ev;
        logic [STAGES*DATA_W-1:0] ed;
        for (int s = 0; s < STAGES; s++) begin
            ev[s] = m_pipe[s].v;
            ed[s*DATA_W +: DATA_W] = m_pipe[s].d;
        end
        check("model_stage_valid", stage_valid, ev);
        check("model_stage_data", stage_data, ed);
        check("model_num_inst", num_inst, m_num);
        check("model_output_port", output_port, m_port);
        check("model_is_halted", is_halted, m_halted);
        check("model_stall_cycles", stall_cycles, STATS ? m_sc : '0);
        check("model_bubble_count", bubble_count, STATS ? m_bc : '0);
    endtask

    // One clock: drive, check combinational ready, advance model, compare after the edge.
    task automatic cycle(input logic rn, input logic iv, input logic [DATA_W-1:0] id,
                         input logic iw, input logic ih, input logic sm, input logic hd,
                         input logic fl);
        reset_n = rn; in_valid = iv; in_data = id; in_wwd = iw; in_halt = ih;
        stall_mem = sm; hold = hd; flush = fl;
        #1;
        if (rn) check("in_ready", in_ready, !sm && !hd && !m_halted);
        model_step();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rst();
        cycle(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [DATA_W-1:0] d, input logic w, input logic h);
        cycle(1'b1, 1'b1, d, w, h, 1'b0, 1'b0, 1'b0);
    endtask

    typedef struct {
        logic              rn, iv;
        logic [DATA_W-1:0] id;
        logic              iw, ih, sm, hd, fl;
        logic [STAGES-1:0] ev;
        logic [CNT_W-1:0]  en;
        logic [DATA_W-1:0] ep;
        logic              eh;
    } vec_t;

    vec_t tbl[18];

    initial begin
        // rn iv data iw ih sm hd fl | stage_valid num port halted
        tbl[0]  = '{0, 0, 16'h0000, 0, 0, 0, 0, 0, 5'b00000, 0, 16'h0000, 0};
        tbl[1]  = '{1, 1, 16'h0001, 0, 0, 0, 0, 0, 5'b00001, 0, 16'h0000, 0};
        tbl[2]  = '{1, 1, 16'h0002, 0, 0, 0, 0, 0, 5'b00011, 0, 16'h0000, 0};
        tbl[3]  = '{1, 1, 16'h0003, 0, 0, 0, 0, 0, 5'b00111, 0, 16'h0000, 0};
        tbl[4]  = '{1, 1, 16'h0004, 0, 0, 0, 0, 0, 5'b01111, 0, 16'h0000, 0};
        tbl[5]  = '{1, 0, 16'h0000, 0, 0, 0, 0, 0, 5'b11110, 0, 16'h0000, 0};
        tbl[6]  = '{1, 0, 16'h0000, 0, 0, 0, 0, 0, 5'b11100, 1, 16'h0000, 0};
        tbl[7]  = '{1, 0, 16'h0000, 0, 0, 0, 0, 0, 5'b11000, 2, 16'h0000, 0};
        tbl[8]  = '{1, 0, 16'h0000, 0, 0, 0, 0, 0, 5'b10000, 3, 16'h0000, 0};
        tbl[9]  = '{1, 0, 16'h0000, 0, 0, 0, 0, 0, 5'b00000, 4, 16'h0000, 0};
        tbl[10] = '{1, 1, 16'h00AB, 1, 0, 0, 0, 0, 5'b00001, 4, 16'h0000, 0};
        tbl[11] = '{1, 0, 16'h0000, 0, 0, 0, 0, 0, 5'b00010, 4, 16'h0000, 0};
        tbl[12] = '{1, 0, 16'h0000, 0, 0, 0, 0, 0, 5'b00100, 4, 16'h0000, 0};
        tbl[13] = '{1, 0, 16'h0000, 0, 0, 0, 0, 0, 5'b01000, 4, 16'h0000, 0};
        tbl[14] = '{1, 0, 16'h0000, 0, 0, 0, 0, 0, 5'b10000, 4, 16'h0000, 0};
        tbl[15] = '{1, 0, 16'h0000, 0, 0, 0, 0, 0, 5'b00000, 5, 16'h00AB, 0};
        tbl[16] = '{1, 1, 16'h0055, 0, 0, 0, 0, 1, 5'b00000, 5, 16'h00AB, 0};
        tbl[17] = '{1, 0, 16'h0000, 0, 0, 0, 0, 1, 5'b00000, 5, 16'h00AB, 0};

        model_reset();

        for (int i = 0; i < 18; i++) begin
            cycle(tbl[i].rn, tbl[i].iv, tbl[i].id, tbl[i].iw, tbl[i].ih,
                  tbl[i].sm, tbl[i].hd, tbl[i].fl);
            check($sformatf("tbl%0d_stage_valid", i), stage_valid, tbl[i].ev);
            check($sformatf("tbl%0d_num_inst", i), num_inst, tbl[i].en);
            check($sformatf("tbl%0d_output_port", i), output_port, tbl[i].ep);
            check($sformatf("tbl%0d_is_halted", i), is_halted, tbl[i].eh);
        end

        // Hold: A in stage 1, B in stage 0, two bubbles, A retires two edges late.
        rst();
        push(16'h000A, 1'b0, 1'b0);
        push(16'h000B, 1'b0, 1'b0);
        repeat (2) cycle(1'b1, 1'b1, 16'h000C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("hold_stage_valid", stage_valid, 5'b00011);
        check("hold_stage0", stage_data[15:0], 16'h000B);
        check("hold_stage1", stage_data[31:16], 16'h000A);
        check("hold_bubble_count", bubble_count, STATS ? 16'd2 : 16'd0);
        repeat (3) idle();
        check("hold_not_yet_retired", num_inst, 16'd0);
        idle();
        check("hold_late_retire", num_inst, 16'd1);
        repeat (2) idle();

        // Freeze with flush on a full pipe.
        rst();
        for (int i = 0; i < 5; i++) push(16'h0010 + 16'(i), 1'b0, 1'b0);
        check("full_stage_valid", stage_valid, 5'b11111);
        repeat (3) cycle(1'b1, 1'b1, 16'h0099, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        check("freeze_stage_valid", stage_valid, 5'b11111);
        check("freeze_num_inst", num_inst, 16'd0);
        check("freeze_stage0", stage_data[15:0], 16'h0014);
        check("freeze_stall_cycles", stall_cycles, STATS ? 16'd3 : 16'd0);
        idle();
        check("unfreeze_retire", num_inst, 16'd1);

        // Halt followed by two WWD entries that must drain uncounted.
        rst();
        push(16'h0011, 1'b0, 1'b1);
        push(16'h0022, 1'b1, 1'b0);
        push(16'h0033, 1'b1, 1'b0);
        repeat (3) idle();
        check("halt_flag", is_halted, 1'b1);
        check("halt_num_inst", num_inst, 16'd1);
        check("halt_in_ready", in_ready, 1'b0);
        repeat (4) cycle(1'b1, 1'b1, 16'h0044, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check("halt_drained", stage_valid, 5'b00000);
        check("halt_num_frozen", num_inst, 16'd1);
        check("halt_port_untouched", output_port, 16'h0000);
        repeat (2) cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("halt_stall_frozen", stall_cycles, 16'd0);
        check("halt_bubble_frozen", bubble_count, 16'd0);
        rst();
        check("reset_halted", is_halted, 1'b0);
        check("reset_num_inst", num_inst, 16'd0);
        check("reset_valid", stage_valid, 5'b00000);
        #1 check("reset_in_ready", in_ready, 1'b1);

        // Reset wins over stall_mem and hold mid-operation.
        for (int i = 0; i < 3; i++) push(16'h0070 + 16'(i), 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0077, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        check("midreset_valid", stage_valid, 5'b00000);
        check("midreset_data", stage_data, '0);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 199) != 0,
                  $urandom_range(0, 3) != 0,
                  DATA_W'($urandom),
                  $urandom_range(0, 3) == 0,
                  $urandom_range(0, 149) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 4) == 0,
                  $urandom_range(0, 5) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
